mips_cpu_fetch_unit: RTL and testbench

MIPS_CPU_FETCH_UNIT -- requirements
Module: mips_cpu_fetch_unit

---
 rtl/mips_cpu_pkg.sv | 21 ++
 rtl/mips_cpu_fetch_unit.sv | 113 +++++++++++
 tb/tb_mips_cpu_fetch_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared constants and types for the MIPS CPU front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_cpu_pkg;

    // Address of the first instruction fetched after reset (kseg1 boot ROM).
    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Sequential successor of a word address; wraps modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/mips_cpu_fetch_unit.sv
// Instruction fetch: reads one word per pc, holds it for the IR, follows delayed-slot branch redirects.
// Latency: read asserts 1 cycle after reset release; word presented the cycle after waitrequest drops.
// Backpressure: mem_waitrequest holds the read; instr_ready low holds the word and stalls fetch.
module mips_cpu_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = mips_cpu_pkg::RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        active,
    output logic        fetch_fault
);

    import mips_cpu_pkg::*;

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    logic        r_run;      // low for the reset cycle so no read is issued before the first edge
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_armed;
    logic [31:0] r_target;
    logic        r_fault;

    logic        w_fire;
    logic        w_xfer;
    logic [31:0] w_next_pc;
    logic        w_misaligned;
    logic        w_zero;

    assign w_fire       = mem_read & ~mem_waitrequest;
    assign w_xfer       = instr_valid & instr_ready;
    assign w_next_pc    = r_armed ? r_target : pc_plus4(r_pc);
    assign w_misaligned = |w_next_pc[1:0];
    assign w_zero       = (w_next_pc == 32'h0000_0000);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: capture ends FETCH, transfer ends HOLD, HALTED is left only by reset.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH:   if (w_fire) w_next_state = HOLD;
            HOLD:    if (w_xfer) w_next_state = (w_zero || w_misaligned) ? HALTED : FETCH;
            HALTED:  w_next_state = HALTED;
            default: w_next_state = FETCH;
        endcase
    end

    // Outputs decoded from state; instr_out comes only from the capture register.
    always_comb begin
        mem_read       = (r_state == FETCH) && r_run;
        mem_byteenable = mem_read ? 4'hF : 4'h0;
        mem_address    = r_pc;
        instr_valid    = (r_state == HOLD);
        instr_out      = r_instr;
        instr_pc       = r_instr_pc;
        active         = (r_state != HALTED);
        fetch_fault    = r_fault;
    end

    // Datapath: pc advance, word capture, delay-slot redirect bookkeeping, sticky fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_pc       <= RESET_VECTOR;
            r_instr    <= 32'h0;
            r_instr_pc <= 32'h0;
            r_armed    <= 1'b0;
            r_target   <= 32'h0;
            r_fault    <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_fire) begin
                r_instr    <= mem_readdata;
                r_instr_pc <= r_pc;
            end
            if (w_xfer && !w_zero && !w_misaligned) begin
                r_pc <= w_next_pc;
            end
            if (w_xfer && w_misaligned) begin
                r_fault <= 1'b1;
            end
            // A transfer in the latch cycle uses the old next_pc; the new target waits for the next one.
            if (w_xfer && r_armed) begin
                r_armed <= 1'b0;
            end else if (branch_taken && !r_armed && (r_state != HALTED)) begin
                r_armed  <= 1'b1;
                r_target <= branch_target;
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_fetch_unit.sv
// Directed bench for the fetch unit: boot fetch, stalls, delayed branches, halt, fault, reset mid-read.
// Latency: checks sampled 2 time units after each rising edge.
// Backpressure: drives mem_waitrequest and instr_ready explicitly per step.
module tb_mips_cpu_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        active;
    logic        fetch_fault;

    int n_tests;
    int n_fail;

    mips_cpu_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_byteenable  (mem_byteenable),
        .mem_waitrequest (mem_waitrequest),
        .mem_readdata    (mem_readdata),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .active          (active),
        .fetch_fault     (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns a scrambled copy of the address so each word is distinguishable.
    assign mem_readdata = mem_address ^ 32'hA5A5_5A5A;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n           = 1'b0;
        mem_waitrequest = 1'b0;
        instr_ready     = 1'b0;
        branch_taken    = 1'b0;
        branch_target   = 32'h0;

        // Reset state
        #12;
        check_val("rst_mem_read", mem_read, 1'b0);
        check_val("rst_be", mem_byteenable, 4'h0);
        check_val("rst_valid", instr_valid, 1'b0);
        check_val("rst_active", active, 1'b1);
        check_val("rst_fault", fetch_fault, 1'b0);
        check_val("rst_instr_out", instr_out, 32'h0);
        check_val("rst_instr_pc", instr_pc, 32'h0);
        check_val("rst_addr", mem_address, 32'hBFC0_0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Boot fetch with no wait states
        tick();
        check_val("boot_read", mem_read, 1'b1);
        check_val("boot_addr", mem_address, 32'hBFC0_0000);
        check_val("boot_be", mem_byteenable, 4'hF);
        check_val("boot_valid_c1", instr_valid, 1'b0);
        tick();
        check_val("boot_valid_c2", instr_valid, 1'b1);
        check_val("boot_pc", instr_pc, 32'hBFC0_0000);
        check_val("boot_data", instr_out, 32'h1A65_5A5A);
        check_val("hold_read", mem_read, 1'b0);
        check_val("hold_be", mem_byteenable, 4'h0);
        tick();
        check_val("hold_stable_valid", instr_valid, 1'b1);
        check_val("hold_stable_data", instr_out, 32'h1A65_5A5A);
        instr_ready = 1'b1;

        // Accept BFC00000, then branch to BFC00100 from execute
        tick();
        check_val("seq_addr", mem_address, 32'hBFC0_0004);
        check_val("seq_read", mem_read, 1'b1);
        check_val("seq_valid", instr_valid, 1'b0);
        instr_ready   = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'hBFC0_0100;
        tick();
        branch_taken = 1'b0;
        check_val("slot_pc", instr_pc, 32'hBFC0_0004);
        check_val("slot_data", instr_out, 32'h1A65_5A5E);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_val("tgt_addr", mem_address, 32'hBFC0_0100);
        check_val("tgt_read", mem_read, 1'b1);
        mem_waitrequest = 1'b1;
        tick();
        check_val("tgt_stall_addr", mem_address, 32'hBFC0_0100);
        check_val("tgt_stall_valid", instr_valid, 1'b0);

        // Reset during a stalled read
        #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst_read", mem_read, 1'b0);
        check_val("midrst_addr", mem_address, 32'hBFC0_0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Three wait-state cycles then capture
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("stall_addr_%0d", i), mem_address, 32'hBFC0_0000);
            check_val($sformatf("stall_read_%0d", i), mem_read, 1'b1);
            check_val($sformatf("stall_valid_%0d", i), instr_valid, 1'b0);
        end
        mem_waitrequest = 1'b0;
        #1;
        check_val("stall_addr_3", mem_address, 32'hBFC0_0000);
        tick();
        check_val("stall_cap_valid", instr_valid, 1'b1);
        check_val("stall_cap_pc", instr_pc, 32'hBFC0_0000);
        tick();
        check_val("single_cap_read", mem_read, 1'b0);
        check_val("single_cap_valid", instr_valid, 1'b1);

        // Branch to 0 in the same cycle as a transfer: old next_pc used first
        instr_ready   = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0000;
        tick();
        instr_ready   = 1'b0;
        branch_target = 32'hBFC0_0200;
        check_val("same_cyc_addr", mem_address, 32'hBFC0_0004);
        check_val("same_cyc_active", active, 1'b1);
        // branch_taken still high with a new target: ignored while armed
        tick();
        branch_taken = 1'b0;
        check_val("ds_pc", instr_pc, 32'hBFC0_0004);
        instr_ready = 1'b1;
        tick();
        check_val("halt_active", active, 1'b0);
        check_val("halt_read", mem_read, 1'b0);
        check_val("halt_valid", instr_valid, 1'b0);
        check_val("halt_fault", fetch_fault, 1'b0);
        branch_taken  = 1'b1;
        branch_target = 32'hBFC0_0000;
        tick();
        tick();
        branch_taken = 1'b0;
        check_val("halt_stay_read", mem_read, 1'b0);
        check_val("halt_stay_active", active, 1'b0);

        // Misaligned redirect
        instr_ready = 1'b0;
        rst_n = 1'b0;
        #3;
        check_val("rst2_active", active, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check_val("mis_boot_valid", instr_valid, 1'b1);
        instr_ready = 1'b1;
        tick();
        instr_ready   = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'hBFC0_0102;
        tick();
        branch_taken = 1'b0;
        check_val("mis_slot_pc", instr_pc, 32'hBFC0_0004);
        check_val("mis_pre_fault", fetch_fault, 1'b0);
        instr_ready = 1'b1;
        tick();
        check_val("mis_fault", fetch_fault, 1'b1);
        check_val("mis_active", active, 1'b0);
        check_val("mis_read", mem_read, 1'b0);
        tick();
        check_val("mis_fault_sticky", fetch_fault, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
